// File: rtl/apb_ram_ws_pkg.sv
// Shared types and helpers for the wait-state APB RAM slave.
package apb_ram_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_ram_state_e;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/apb_ram_ws_if.sv
// APB bus bundle between the decoder (master) and the RAM slave.
interface apb_ram_ws_if
    import apb_ram_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]     PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_STRB_W-1:0] PSTRB;
    logic                  PWRITE;
    logic                  PENABLE;
    logic                  PSEL;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_ram_ws_ram_bytewise.sv
// Byte-writable 32-bit word array with one registered read port; storage is never reset.
module ram_bytewise
    import apb_ram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                  clk_i,
    input  logic [APB_STRB_W-1:0] we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    output logic [APB_DATA_W-1:0] rdata_o
);
    logic [APB_DATA_W-1:0] mem_q [DEPTH];
    logic [APB_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < APB_STRB_W; i++) begin
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/apb_ram_ws.sv
// APB slave SRAM with byte strobes, programmable wait states and PSLVERR on bad addresses.
module apb_ram_ws
    import apb_ram_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_ram_ws_if.slave  apb
);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_ram_state_e        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic [APB_STRB_W-1:0] strb_q, strb_d;
    logic                  write_q, write_d;

    logic                  access, commit, err;
    logic [ADDR_W-1:0]     c_addr;
    logic [APB_DATA_W-1:0] c_wdata;
    logic [APB_STRB_W-1:0] c_strb;
    logic                  c_write;
    logic [APB_STRB_W-1:0] ram_we;
    logic                  ram_re;
    logic [APB_DATA_W-1:0] ram_rdata;

    assign access = apb.PSEL & apb.PENABLE;

    // With zero wait states the commit happens on the latching edge, so use the live bus.
    always_comb begin
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_strb  = strb_q;
        c_write = write_q;
        if (state_q == IDLE) begin
            c_addr  = apb.PADDR;
            c_wdata = apb.PWDATA;
            c_strb  = apb.PSTRB;
            c_write = apb.PWRITE;
        end
    end

    assign err = (c_addr[1:0] != 2'b00) | ~word_in_range(32'(c_addr[ADDR_W-1:2]), DEPTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        rd_valid_d = rd_valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        write_d    = write_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = apb.PADDR;
                    wdata_d = apb.PWDATA;
                    strb_d  = apb.PSTRB;
                    write_d = apb.PWRITE;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) commit = 1'b1;
                    else                  state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!apb.PSEL)        state_d = IDLE;
                else if (cnt_q == 4'd1) commit = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = err;
            if (err)           rd_valid_d = 1'b0;
            else if (!c_write) rd_valid_d = 1'b1;
        end
    end

    // Gating with PRESETn keeps a held bus from writing memory while reset is asserted.
    assign ram_we = {APB_STRB_W{commit & ~err & c_write & PRESETn}} & c_strb;
    assign ram_re = commit & ~err & ~c_write & PRESETn;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge PCLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        strb_q  <= strb_d;
        write_q <= write_d;
    end

    ram_bytewise #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (PCLK),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (c_addr[IDX_W+1:2]),
        .wdata_i (c_wdata),
        .rdata_o (ram_rdata)
    );

    // PRDATA reads as zero after reset or an error until the next good read.
    assign apb.PRDATA  = rd_valid_q ? ram_rdata : '0;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
endmodule
